// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types and timing constants for the per-level context-save (PCS) sequencer
// and the PCS memory it talks to.
package rt_ibex_pcs_pkg;

    localparam int unsigned PcsNrSavedRegs   = 9;
    localparam int unsigned PcsDataWidth     = 32;
    localparam int unsigned PcsIrqLevelWidth = 8;
    localparam int unsigned PcsMaxNest       = 8;

    // Memory write cycle plus address update cycle after the store request.
    localparam int unsigned SaveSettleCycles = 2;
    localparam int unsigned RestoreTimeout   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_SWAIT,
        ST_RREQ,
        ST_RWAIT,
        ST_WB
    } state_t;

    typedef logic [PcsNrSavedRegs-1:0][PcsDataWidth-1:0] ctx_t;

endpackage

// File: rtl/rt_ibex_pcs_ctrl.sv
// Initiator-side save/restore sequencer between the ibex controller/register file
// and the PCS memory; stalls the core while a context moves in either direction.
module rt_ibex_pcs_ctrl
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned NrSavedRegs   = PcsNrSavedRegs,
    parameter int unsigned DataWidth     = PcsDataWidth,
    parameter int unsigned IrqLevelWidth = PcsIrqLevelWidth,
    parameter int unsigned MaxNest       = PcsMaxNest,
    localparam int unsigned DepthW       = $clog2(MaxNest + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      irq_take_i,
    input  logic [IrqLevelWidth-1:0]                  irq_level_i,
    input  logic                                      mret_i,
    output logic                                      stall_o,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]     rf_save_data_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]     rf_restore_data_o,
    output logic                                      rf_restore_we_o,
    output logic                                      pcs_irq_ack_o,
    output logic [IrqLevelWidth-1:0]                  pcs_irq_level_o,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]     pcs_store_data_o,
    output logic                                      pcs_next_mret_o,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]     pcs_restore_data_i,
    input  logic                                      pcs_restore_en_i,
    output logic                                      pcs_irq_exit_o,
    output logic [DepthW-1:0]                         depth_o,
    output logic                                      overflow_o,
    output logic                                      underflow_o
);

    state_t                                  r_state;
    logic [NrSavedRegs-1:0][DataWidth-1:0]   r_snapshot;
    logic [NrSavedRegs-1:0][DataWidth-1:0]   r_restore;
    logic [IrqLevelWidth-1:0]                r_level;
    logic [DepthW-1:0]                       r_depth;
    logic [1:0]                              r_settle_cnt;
    logic [1:0]                              r_wait_cnt;
    logic                                    r_mret_pend;
    logic                                    r_ack;
    logic                                    r_next_mret;
    logic                                    r_we;
    logic                                    r_exit;
    logic                                    r_overflow;
    logic                                    r_underflow;

    logic w_can_save;
    logic w_can_restore;

    assign w_can_save    = (r_depth < DepthW'(MaxNest));
    assign w_can_restore = (r_depth != '0);

    // The request terms raise stall in the same cycle the core presents the request.
    assign stall_o = (r_state != ST_IDLE)
                   | (irq_take_i & w_can_save)
                   | (mret_i & w_can_restore);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            // NOTE: the context registers are wide but are still cleared so no stale
            // register contents ever appear on the store or write-back buses after reset.
            r_snapshot   <= '0;
            r_restore    <= '0;
            r_level      <= '0;
            r_depth      <= '0;
            r_settle_cnt <= '0;
            r_wait_cnt   <= '0;
            r_mret_pend  <= 1'b0;
            r_ack        <= 1'b0;
            r_next_mret  <= 1'b0;
            r_we         <= 1'b0;
            r_exit       <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are set on entry to the
            // state that owns them, so each is a registered one-cycle strobe.
            r_ack       <= 1'b0;
            r_next_mret <= 1'b0;
            r_we        <= 1'b0;
            r_exit      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (irq_take_i && w_can_save) begin
                        r_snapshot  <= rf_save_data_i;
                        r_level     <= irq_level_i;
                        r_mret_pend <= mret_i;
                        r_ack       <= 1'b1;
                        r_state     <= ST_ACK;
                    end else begin
                        if (irq_take_i) begin
                            r_overflow <= 1'b1;
                        end
                        if (mret_i && w_can_restore) begin
                            r_next_mret <= 1'b1;
                            r_state     <= ST_RREQ;
                        end else if (mret_i) begin
                            r_underflow <= 1'b1;
                        end
                    end
                end

                ST_ACK: begin
                    r_settle_cnt <= 2'(SaveSettleCycles);
                    r_state      <= ST_SWAIT;
                end

                ST_SWAIT: begin
                    r_settle_cnt <= r_settle_cnt - 2'd1;
                    if (r_settle_cnt == 2'd1) begin
                        r_depth <= r_depth + DepthW'(1);
                        if (r_mret_pend) begin
                            r_mret_pend <= 1'b0;
                            r_next_mret <= 1'b1;
                            r_state     <= ST_RREQ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_RREQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_RWAIT;
                end

                ST_RWAIT: begin
                    if (pcs_restore_en_i) begin
                        r_restore <= pcs_restore_data_i;
                        r_we      <= 1'b1;
                        r_exit    <= 1'b1;
                        r_state   <= ST_WB;
                    end else if (r_wait_cnt == 2'(RestoreTimeout - 1)) begin
                        r_underflow <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end

                ST_WB: begin
                    r_depth <= r_depth - DepthW'(1);
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rf_restore_data_o = r_restore;
    assign rf_restore_we_o   = r_we;
    assign pcs_irq_ack_o     = r_ack;
    assign pcs_irq_level_o   = r_level;
    assign pcs_store_data_o  = r_snapshot;
    assign pcs_next_mret_o   = r_next_mret;
    assign pcs_irq_exit_o    = r_exit;
    assign depth_o           = r_depth;
    assign overflow_o        = r_overflow;
    assign underflow_o       = r_underflow;

endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Directed bench for rt_ibex_pcs_ctrl: cycle-accurate checks of save, restore,
// nesting limits, combined take/mret, restore timeout and mid-sequence reset.
module tb_rt_ibex_pcs_ctrl;
    import rt_ibex_pcs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        irq_take;
    logic [7:0]  irq_level;
    logic        mret;
    logic        stall;
    ctx_t        rf_save;
    ctx_t        rf_restore_data;
    logic        rf_we;
    logic        ack;
    logic [7:0]  level_o;
    ctx_t        store_data;
    logic        next_mret;
    ctx_t        restore_data;
    logic        restore_en;
    logic        irq_exit;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    rt_ibex_pcs_ctrl dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .irq_take_i         (irq_take),
        .irq_level_i        (irq_level),
        .mret_i             (mret),
        .stall_o            (stall),
        .rf_save_data_i     (rf_save),
        .rf_restore_data_o  (rf_restore_data),
        .rf_restore_we_o    (rf_we),
        .pcs_irq_ack_o      (ack),
        .pcs_irq_level_o    (level_o),
        .pcs_store_data_o   (store_data),
        .pcs_next_mret_o    (next_mret),
        .pcs_restore_data_i (restore_data),
        .pcs_restore_en_i   (restore_en),
        .pcs_irq_exit_o     (irq_exit),
        .depth_o            (depth),
        .overflow_o         (overflow),
        .underflow_o        (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        rst_n = 1'b0;
        irq_take = 1'b0; mret = 1'b0; irq_level = '0;
        restore_en = 1'b0; restore_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Plain stimulus for a complete save sequence; ends on the cycle after IDLE returns.
    task automatic drive_take(input logic [7:0] lvl);
        @(negedge clk); irq_take = 1'b1; irq_level = lvl;
        @(negedge clk); irq_take = 1'b0; irq_level = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irq_take = 1'b0; mret = 1'b0; irq_level = '0;
        restore_en = 1'b0; restore_data = '0; rf_save = '0;
        @(negedge clk); #1;
        if ({stall, ack, next_mret, rf_we, irq_exit, overflow, underflow} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000",
                {stall, ack, next_mret, rf_we, irq_exit, overflow, underflow});
        end
        checks++;
        if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++;
        if (store_data !== '0 || rf_restore_data !== '0 || level_o !== 8'd0) begin
            errors++; $display("FAIL reset_data: store %0h restore %0h level %0h want all 0",
                store_data, rf_restore_data, level_o);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_take();
        ctx_t exp_ctx;
        for (int i = 0; i < 9; i++) rf_save[i] = 32'h100 + i;
        exp_ctx = rf_save;
        @(negedge clk); irq_take = 1'b1; irq_level = 8'd3; #1;
        if (stall !== 1'b1) begin errors++; $display("FAIL take_stall_t0: got %b want 1", stall); end
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL take_ack_t0: got %b want 0", ack); end
        checks++;
        @(negedge clk); irq_take = 1'b0; irq_level = '0;
        for (int i = 0; i < 9; i++) rf_save[i] = 32'hDEAD_0000 + i;
        #1;
        if (ack !== 1'b1) begin errors++; $display("FAIL take_ack_t1: got %b want 1", ack); end
        checks++;
        if (store_data !== exp_ctx) begin
            errors++; $display("FAIL take_store_t1: got %0h want %0h", store_data, exp_ctx);
        end
        checks++;
        if (level_o !== 8'd3) begin errors++; $display("FAIL take_level_t1: got %0d want 3", level_o); end
        checks++;
        for (int t = 2; t <= 3; t++) begin
            @(negedge clk); #1;
            if ({stall, ack, depth} !== {1'b1, 1'b0, 4'd0}) begin
                errors++; $display("FAIL take_swait_t%0d: stall %b ack %b depth %0d want 1 0 0",
                    t, stall, ack, depth);
            end
            checks++;
            if (store_data !== exp_ctx) begin
                errors++; $display("FAIL take_store_stable_t%0d: got %0h want %0h", t, store_data, exp_ctx);
            end
            checks++;
        end
        @(negedge clk); #1;
        if ({stall, depth} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL take_done_t4: stall %b depth %0d want 0 1", stall, depth);
        end
        checks++;
    endtask

    task automatic test_take_mret();
        ctx_t exp_ctx;
        for (int i = 0; i < 9; i++) exp_ctx[i] = 32'hA0 + i;
        @(negedge clk); mret = 1'b1; #1;
        if ({stall, next_mret} !== 2'b10) begin
            errors++; $display("FAIL mret_t0: stall %b next_mret %b want 1 0", stall, next_mret);
        end
        checks++;
        @(negedge clk); mret = 1'b0; #1;
        if ({stall, next_mret} !== 2'b11) begin
            errors++; $display("FAIL mret_req_t1: stall %b next_mret %b want 1 1", stall, next_mret);
        end
        checks++;
        @(negedge clk); #1;
        if ({stall, next_mret, rf_we} !== 3'b100) begin
            errors++; $display("FAIL mret_wait_t2: stall %b next_mret %b we %b want 1 0 0", stall, next_mret, rf_we);
        end
        checks++;
        @(negedge clk); restore_en = 1'b1; restore_data = exp_ctx; #1;
        if ({stall, rf_we} !== 2'b10) begin
            errors++; $display("FAIL mret_rsp_t3: stall %b we %b want 1 0", stall, rf_we);
        end
        checks++;
        @(negedge clk); restore_en = 1'b0; restore_data = '0; #1;
        if ({stall, rf_we, irq_exit, depth} !== {3'b111, 4'd1}) begin
            errors++; $display("FAIL mret_wb_t4: stall %b we %b exit %b depth %0d want 1 1 1 1",
                stall, rf_we, irq_exit, depth);
        end
        checks++;
        if (rf_restore_data !== exp_ctx) begin
            errors++; $display("FAIL mret_wb_data: got %0h want %0h", rf_restore_data, exp_ctx);
        end
        checks++;
        @(negedge clk); #1;
        if ({stall, rf_we, irq_exit, depth, underflow} !== {3'b000, 4'd0, 1'b0}) begin
            errors++; $display("FAIL mret_done_t5: stall %b we %b exit %b depth %0d uf %b want 0 0 0 0 0",
                stall, rf_we, irq_exit, depth, underflow);
        end
        checks++;
    endtask

    task automatic test_nesting();
        logic seen_stall;
        logic seen_ack;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); irq_take = 1'b1; irq_level = 8'(k + 1); #1;
            seen_stall = stall;
            @(negedge clk); irq_take = 1'b0; irq_level = '0; #1;
            seen_ack = ack;
            repeat (3) @(negedge clk);
            #1;
            if ({seen_stall, seen_ack} !== ((k < 8) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL nest_take%0d: stall %b ack %b want %b",
                    k, seen_stall, seen_ack, (k < 8) ? 2'b11 : 2'b00);
            end
            checks++;
            if (k == 7 && {overflow, depth} !== {1'b0, 4'd8}) begin
                errors++; $display("FAIL nest_full: overflow %b depth %0d want 0 8", overflow, depth);
            end
            if (k == 7) checks++;
        end
        if ({overflow, depth, stall} !== {1'b1, 4'd8, 1'b0}) begin
            errors++; $display("FAIL nest_overflow: overflow %b depth %0d stall %b want 1 8 0",
                overflow, depth, stall);
        end
        checks++;
    endtask

    task automatic test_mret_underflow();
        reset_dut();
        @(negedge clk); mret = 1'b1; #1;
        if (stall !== 1'b0) begin errors++; $display("FAIL uf_stall_t0: got %b want 0", stall); end
        checks++;
        @(negedge clk); mret = 1'b0; #1;
        if ({next_mret, underflow, stall, depth} !== {3'b010, 4'd0}) begin
            errors++; $display("FAIL uf_t1: next_mret %b uf %b stall %b depth %0d want 0 1 0 0",
                next_mret, underflow, stall, depth);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int ack_cnt;
        int we_cnt;
        ctx_t exp_ctx;
        reset_dut();
        for (int i = 0; i < 9; i++) rf_save[i] = 32'h200 + i;
        drive_take(8'd1);
        for (int i = 0; i < 9; i++) exp_ctx[i] = 32'hB0 + i;
        ack_cnt = 0; we_cnt = 0;
        @(negedge clk); irq_take = 1'b1; mret = 1'b1; irq_level = 8'd5; #1;
        if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_t0: got %b want 1", stall); end
        checks++;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            irq_take = 1'b0; mret = 1'b0; irq_level = '0;
            restore_en = (t == 6);
            restore_data = (t == 6) ? exp_ctx : '0;
            #1;
            ack_cnt += int'(ack);
            we_cnt  += int'(rf_we);
            if (t == 1 && ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_t1: got %b want 1", ack); end
            if (t == 1) checks++;
            if (t == 3 && next_mret !== 1'b0) begin errors++; $display("FAIL b2b_early_req_t3: got %b want 0", next_mret); end
            if (t == 3) checks++;
            if (t == 4 && {next_mret, depth} !== {1'b1, 4'd2}) begin
                errors++; $display("FAIL b2b_req_t4: next_mret %b depth %0d want 1 2", next_mret, depth);
            end
            if (t == 4) checks++;
            if (t == 7 && (rf_we !== 1'b1 || rf_restore_data !== exp_ctx)) begin
                errors++; $display("FAIL b2b_wb_t7: we %b data %0h want 1 %0h", rf_we, rf_restore_data, exp_ctx);
            end
            if (t == 7) checks++;
        end
        if ({depth, stall} !== {4'd1, 1'b0}) begin
            errors++; $display("FAIL b2b_done: depth %0d stall %b want 1 0", depth, stall);
        end
        checks++;
        if (ack_cnt != 1 || we_cnt != 1) begin
            errors++; $display("FAIL b2b_pulses: acks %0d writebacks %0d want 1 1", ack_cnt, we_cnt);
        end
        checks++;
    endtask

    task automatic test_timeout_and_reset();
        int we_cnt;
        we_cnt = 0;
        @(negedge clk); mret = 1'b1;
        @(negedge clk); mret = 1'b0; #1;
        if (next_mret !== 1'b1) begin errors++; $display("FAIL to_req_t1: got %b want 1", next_mret); end
        checks++;
        for (int t = 2; t <= 5; t++) begin
            @(negedge clk); #1;
            we_cnt += int'(rf_we);
        end
        if ({stall, underflow} !== 2'b10) begin
            errors++; $display("FAIL to_rwait_t5: stall %b uf %b want 1 0", stall, underflow);
        end
        checks++;
        @(negedge clk); #1;
        if ({stall, underflow, depth} !== {2'b01, 4'd1} || we_cnt != 0) begin
            errors++; $display("FAIL to_done_t6: stall %b uf %b depth %0d writebacks %0d want 0 1 1 0",
                stall, underflow, depth, we_cnt);
        end
        checks++;
        @(negedge clk); irq_take = 1'b1; irq_level = 8'd7;
        @(negedge clk); irq_take = 1'b0; irq_level = '0;
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        if ({stall, ack, next_mret, rf_we, irq_exit, overflow, underflow} !== 7'b0 || depth !== 4'd0) begin
            errors++; $display("FAIL midreset_flags: flags %b depth %0d want 0000000 0",
                {stall, ack, next_mret, rf_we, irq_exit, overflow, underflow}, depth);
        end
        checks++;
        if (store_data !== '0 || level_o !== 8'd0) begin
            errors++; $display("FAIL midreset_data: store %0h level %0h want 0 0", store_data, level_o);
        end
        checks++;
        @(negedge clk); rst_n = 1'b1;
        we_cnt = 0;
        repeat (4) begin
            @(negedge clk); #1;
            we_cnt += int'(rf_we | stall | ack);
        end
        if (we_cnt != 0 || depth !== 4'd0) begin
            errors++; $display("FAIL midreset_after: activity %0d depth %0d want 0 0", we_cnt, depth);
        end
        checks++;
    endtask

    initial begin
        rf_save = '0;
        test_reset();
        test_single_take();
        test_take_mret();
        test_nesting();
        test_mret_underflow();
        test_back_to_back();
        test_timeout_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
